// File: rtl/pix_pack_pkg.sv
// Shared constants and width helpers for the pixel packing FIFO.
// Slot placement lives here so the assembler and any checker agree on beat order.
package pix_pack_pkg;

    localparam int AF_MARGIN  = 4;
    localparam int AE_LVL_DEF = 4;

    function automatic int calc_out_w(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int calc_bp_w(input int ratio);
        return $clog2(ratio);
    endfunction

    // LSB position of beat slot k inside the packed word.
    function automatic int slot_lsb(input int slot, input int in_w, input int ratio,
                                    input bit first_msb);
        if (first_msb)
            return (ratio - 1 - slot) * in_w;
        else
            return slot * in_w;
    endfunction

endpackage

// File: rtl/pix_pack_fifo_if.sv
// Beat-in / word-out bus of the pixel packing FIFO, with status outputs.
// master = 8080 capture plus RGB engine side, slave = the FIFO.
interface pix_pack_fifo_if
    import pix_pack_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int RATIO = 2,
    parameter int DEPTH = 512
);
    localparam int OUT_W = calc_out_w(IN_W, RATIO);
    localparam int CNT_W = calc_cnt_w(DEPTH);
    localparam int BP_W  = calc_bp_w(RATIO);

    logic             clr;
    logic [IN_W-1:0]  di;
    logic             we;
    logic             re;
    logic [OUT_W-1:0] dout;
    logic             empty_flag;
    logic             full_flag;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic [BP_W-1:0]  beat_pend;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, di, we, re,
        input  dout, empty_flag, full_flag, almost_full, almost_empty,
               count, beat_pend, overflow, underflow
    );

    modport slave (
        input  clr, di, we, re,
        output dout, empty_flag, full_flag, almost_full, almost_empty,
               count, beat_pend, overflow, underflow
    );

endinterface

// File: rtl/pix_pack_ram.sv
// Simple dual-port word store: one write port, one registered read port.
// Only the read register is reset/cleared; the array itself is never reset.
module pix_pack_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_data_d;
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (clr)
            rd_data_d = '0;
        else if (rd_en)
            rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_q <= '0;
        else
            rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pix_pack_fifo.sv
// Width-converting FIFO: packs RATIO input beats into one word and buffers DEPTH words.
// Holds the beat assembler, pointers, occupancy count, level flags and sticky error flags.
module pix_pack_fifo
    import pix_pack_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int RATIO     = 2,
    parameter int DEPTH     = 512,
    parameter bit FIRST_MSB = 1'b1,
    parameter int AF_LVL    = DEPTH - AF_MARGIN,
    parameter int AE_LVL    = AE_LVL_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    pix_pack_fifo_if.slave bus
);

    localparam int OUT_W = calc_out_w(IN_W, RATIO);
    localparam int PTR_W = calc_ptr_w(DEPTH);
    localparam int CNT_W = calc_cnt_w(DEPTH);
    localparam int BP_W  = calc_bp_w(RATIO);

    localparam logic [BP_W-1:0]  LAST_BP   = BP_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LVL);
    localparam logic [OUT_W-1:0] SLOT_MASK = {{(OUT_W-IN_W){1'b0}}, {IN_W{1'b1}}};

    logic [OUT_W-1:0] asm_d,       asm_q;
    logic [BP_W-1:0]  beat_pend_d, beat_pend_q;
    logic [PTR_W-1:0] wr_ptr_d,    wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d,    rd_ptr_q;
    logic [CNT_W-1:0] count_d,     count_q;
    logic             overflow_d,  overflow_q;
    logic             underflow_d, underflow_q;

    logic             empty;
    logic             full;
    logic             wa;
    logic             ra;
    logic             last_beat;
    logic             push;
    logic             pop;
    int               lsb;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] rd_data;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    always_comb begin
        wa        = bus.we & ~full;
        ra        = bus.re & ~empty;
        last_beat = (beat_pend_q == LAST_BP);
        push      = wa & last_beat & ~bus.clr;
        pop       = ra & ~bus.clr;
        lsb       = slot_lsb(int'(beat_pend_q), IN_W, RATIO, FIRST_MSB);
        // Merge the incoming beat so the last beat is part of the word written this edge.
        word      = (asm_q & ~(SLOT_MASK << lsb)) | (OUT_W'(bus.di) << lsb);

        asm_d       = asm_q;
        beat_pend_d = beat_pend_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.clr) begin
            asm_d       = '0;
            beat_pend_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wa) begin
                asm_d       = word;
                beat_pend_d = last_beat ? '0 : beat_pend_q + BP_W'(1);
            end
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (bus.we & full)
                overflow_d = 1'b1;
            if (bus.re & empty)
                underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= '0;
            beat_pend_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            beat_pend_q <= beat_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    pix_pack_ram #(
        .W     (OUT_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.clr),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (word),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign bus.dout         = rd_data;
    assign bus.empty_flag   = empty;
    assign bus.full_flag    = full;
    assign bus.almost_full  = (count_q >= AF_CNT);
    assign bus.almost_empty = (count_q <= AE_CNT);
    assign bus.count        = count_q;
    assign bus.beat_pend    = beat_pend_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_pix_pack_fifo.sv
// Directed bench for pix_pack_fifo: three small configurations (MSB-first, LSB-first, 3:1).
// Instance a carries the depth, wrap, simultaneous-op, flush and reset scenarios.
module tb_pix_pack_fifo;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pix_pack_fifo_if #(.IN_W(8), .RATIO(2), .DEPTH(4)) a ();
    pix_pack_fifo_if #(.IN_W(8), .RATIO(2), .DEPTH(4)) b ();
    pix_pack_fifo_if #(.IN_W(8), .RATIO(3), .DEPTH(4)) c ();

    pix_pack_fifo #(.IN_W(8), .RATIO(2), .DEPTH(4), .FIRST_MSB(1'b1), .AF_LVL(3), .AE_LVL(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    pix_pack_fifo #(.IN_W(8), .RATIO(2), .DEPTH(4), .FIRST_MSB(1'b0), .AF_LVL(3), .AE_LVL(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
    pix_pack_fifo #(.IN_W(8), .RATIO(3), .DEPTH(4), .FIRST_MSB(1'b1), .AF_LVL(3), .AE_LVL(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [7:0] beat);
        a.we = 1'b1;
        a.di = beat;
        step();
        a.we = 1'b0;
    endtask

    task automatic rd_a();
        a.re = 1'b1;
        step();
        a.re = 1'b0;
    endtask

    task automatic clr_a();
        a.clr = 1'b1;
        step();
        a.clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        {a.clr, a.we, a.re, a.di} = '0;
        {b.clr, b.we, b.re, b.di} = '0;
        {c.clr, c.we, c.re, c.di} = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset / idle
        chk("rst_empty",  32'(a.empty_flag),   1);
        chk("rst_aempty", 32'(a.almost_empty), 1);
        chk("rst_full",   32'(a.full_flag),    0);
        chk("rst_afull",  32'(a.almost_full),  0);
        chk("rst_count",  32'(a.count),        0);
        chk("rst_dout",   32'(a.dout),         0);
        chk("rst_bp",     32'(a.beat_pend),    0);
        chk("rst_ovf",    32'(a.overflow),     0);
        rd_a();
        chk("unf_set",    32'(a.underflow),    1);
        chk("unf_dout",   32'(a.dout),         0);
        chk("unf_count",  32'(a.count),        0);
        clr_a();
        chk("unf_clr",    32'(a.underflow),    0);

        // Packing order, three configurations in lockstep
        a.we = 1'b1; a.di = 8'h12;
        b.we = 1'b1; b.di = 8'h12;
        c.we = 1'b1; c.di = 8'hAA;
        step();
        chk("a_bp1",  32'(a.beat_pend), 1);
        chk("a_cnt0", 32'(a.count),     0);
        chk("c_bp1",  32'(c.beat_pend), 1);
        a.di = 8'h34; b.di = 8'h34; c.di = 8'hBB;
        step();
        a.we = 1'b0; b.we = 1'b0;
        chk("a_bp0",   32'(a.beat_pend),  0);
        chk("a_cnt1",  32'(a.count),      1);
        chk("a_nempty",32'(a.empty_flag), 0);
        chk("b_cnt1",  32'(b.count),      1);
        chk("c_bp2",   32'(c.beat_pend),  2);
        chk("c_cnt0",  32'(c.count),      0);
        c.di = 8'hCC;
        step();
        c.we = 1'b0;
        chk("c_bp0",  32'(c.beat_pend), 0);
        chk("c_cnt1", 32'(c.count),     1);
        a.re = 1'b1; b.re = 1'b1; c.re = 1'b1;
        step();
        a.re = 1'b0; b.re = 1'b0; c.re = 1'b0;
        chk("a_msb_word", 32'(a.dout), 32'h1234);
        chk("b_lsb_word", 32'(b.dout), 32'h3412);
        chk("c_r3_word",  32'(c.dout), 32'hAABBCC);
        chk("a_empty_again", 32'(a.empty_flag), 1);
        step();
        chk("a_dout_hold", 32'(a.dout), 32'h1234);

        // Fill to full, overflow, drain
        for (int i = 0; i < 8; i++) begin
            wr_a(8'(i));
            if (i == 3) chk("fill_af_lo", 32'(a.almost_full),  0);
            if (i == 3) chk("fill_ae_lo", 32'(a.almost_empty), 0);
            if (i == 5) chk("fill_af_hi", 32'(a.almost_full),  1);
        end
        chk("full_flag",  32'(a.full_flag),   1);
        chk("full_count", 32'(a.count),       4);
        chk("full_af",    32'(a.almost_full), 1);
        chk("full_ovf0",  32'(a.overflow),    0);
        wr_a(8'h08);
        wr_a(8'h09);
        chk("ovf_set",   32'(a.overflow),  1);
        chk("ovf_count", 32'(a.count),     4);
        chk("ovf_bp",    32'(a.beat_pend), 0);
        rd_a(); chk("drain0", 32'(a.dout), 32'h0001);
        chk("drain_nfull", 32'(a.full_flag), 0);
        rd_a(); chk("drain1", 32'(a.dout), 32'h0203);
        rd_a(); chk("drain2", 32'(a.dout), 32'h0405);
        rd_a(); chk("drain3", 32'(a.dout), 32'h0607);
        chk("drain_empty", 32'(a.empty_flag), 1);
        chk("ovf_sticky",  32'(a.overflow),   1);

        // Wrap-around: write one word, read it back, ten times
        for (int r = 0; r < 10; r++) begin
            logic [7:0] hi;
            logic [7:0] lo;
            hi = 8'(8'h10 + 2 * r);
            lo = 8'(8'h11 + 2 * r);
            wr_a(hi);
            wr_a(lo);
            chk("wrap_cnt", 32'(a.count), 1);
            rd_a();
            chk("wrap_word", 32'(a.dout), {16'h0, hi, lo});
        end

        // Simultaneous push and pop, then read at full
        clr_a();
        wr_a(8'h40); wr_a(8'h41); wr_a(8'h42); wr_a(8'h43);
        chk("sim_cnt2", 32'(a.count), 2);
        wr_a(8'h44);
        a.re = 1'b1;
        wr_a(8'h45);
        a.re = 1'b0;
        chk("sim_cnt_hold", 32'(a.count), 2);
        chk("sim_dout",     32'(a.dout),  32'h4041);
        wr_a(8'h46); wr_a(8'h47); wr_a(8'h48); wr_a(8'h49);
        chk("sim_full", 32'(a.full_flag), 1);
        a.re = 1'b1;
        wr_a(8'h4A);
        a.re = 1'b0;
        chk("fullrw_ovf",  32'(a.overflow),  1);
        chk("fullrw_cnt",  32'(a.count),     3);
        chk("fullrw_bp",   32'(a.beat_pend), 0);
        chk("fullrw_dout", 32'(a.dout),      32'h4243);
        rd_a(); chk("sim_drain0", 32'(a.dout), 32'h4445);
        rd_a(); chk("sim_drain1", 32'(a.dout), 32'h4647);
        rd_a(); chk("sim_drain2", 32'(a.dout), 32'h4849);

        // Flush mid-word beats a concurrent write
        wr_a(8'hAA);
        chk("pre_clr_bp", 32'(a.beat_pend), 1);
        a.clr = 1'b1; a.we = 1'b1; a.di = 8'h55;
        step();
        a.clr = 1'b0; a.we = 1'b0;
        chk("clr_bp",    32'(a.beat_pend),  0);
        chk("clr_cnt",   32'(a.count),      0);
        chk("clr_empty", 32'(a.empty_flag), 1);
        chk("clr_ovf",   32'(a.overflow),   0);
        chk("clr_unf",   32'(a.underflow),  0);
        chk("clr_dout",  32'(a.dout),       0);
        wr_a(8'h12); wr_a(8'h34);
        rd_a();
        chk("post_clr_word", 32'(a.dout), 32'h1234);

        // Asynchronous reset mid-stream
        wr_a(8'h77); wr_a(8'h88);
        rd_a();
        wr_a(8'hAA); wr_a(8'hBB); wr_a(8'hCC);
        chk("pre_rst_cnt", 32'(a.count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",   32'(a.count),        0);
        chk("arst_bp",    32'(a.beat_pend),    0);
        chk("arst_dout",  32'(a.dout),         0);
        chk("arst_empty", 32'(a.empty_flag),   1);
        chk("arst_ae",    32'(a.almost_empty), 1);
        chk("arst_ovf",   32'(a.overflow),     0);
        step();
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
